// File: rtl/fetch_queue.sv
// Instruction fetch queue: tags the single outstanding icache request with its PC,
// buffers {pc, inst} pairs in a small FIFO for decode, and flushes on redirect.
module fetch_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [31:0]              req_pc,
  input  logic                     rsp_valid,
  input  logic [31:0]              rsp_inst,
  input  logic                     flush,
  output logic                     fetch_hold,
  output logic                     dec_valid,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_inst,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          pend_valid;
  logic          pend_kill;
  logic [31:0]   pend_pc;

  logic          pop;
  logic          accept;
  logic          retire;
  logic          push;
  logic [SW-1:0] slots_after;

  // Decode handshake: dec_valid/dec_pc/dec_inst are stable register-derived values;
  // an entry transfers on any cycle where dec_valid & dec_ready, except a flush cycle.
  always_comb begin
    dec_valid   = (count != '0);
    pop         = dec_valid & dec_ready & ~flush;
    // The pending request already owns a slot, so hold whenever that leaves no room.
    slots_after = SW'(count) + SW'(pend_valid) - SW'(pop);
    fetch_hold  = (pend_valid & ~rsp_valid) | (slots_after >= SW'(DEPTH));
    accept      = req_valid & ~flush & ~fetch_hold;
    retire      = rsp_valid & pend_valid;
    push        = retire & ~pend_kill & ~flush;
    dec_pc      = dec_valid ? mem_pc[head]   : '0;
    dec_inst    = dec_valid ? mem_inst[head] : NOP;
    occupancy   = count;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]   <= pend_pc;
      mem_inst[tail] <= rsp_inst;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= tail;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A killed request still occupies the icache, so its response must drain before new work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_kill  <= 1'b0;
      pend_pc    <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_kill  <= 1'b0;
      pend_pc    <= req_pc;
    end else if (retire) begin
      pend_valid <= 1'b0;
      pend_kill  <= 1'b0;
    end else if (flush && pend_valid) begin
      pend_kill  <= 1'b1;
    end
  end
endmodule
